// File: rtl/checkpoint_monitor.sv
// Programmable checkpoint table: after start, compares a selected probe channel
// against a masked expected value at cycle-exact points and tallies pass/fail.
module checkpoint_monitor #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [CNT_W-1:0]         cfg_delay,
  input  logic [SEL_W-1:0]         cfg_ch,
  input  logic [DATA_W-1:0]        cfg_value,
  input  logic [DATA_W-1:0]        cfg_mask,
  input  logic                     cfg_last,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_CH*DATA_W-1:0] probe_data,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         pass_count,
  output logic [CNT_W-1:0]         fail_count,
  output logic [ADDR_W-1:0]        cur_idx,
  output logic                     check_pulse,
  output logic                     check_pass,
  output logic                     first_fail_valid,
  output logic [ADDR_W-1:0]        first_fail_idx,
  output logic [DATA_W-1:0]        first_fail_actual
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  delay;
    logic [SEL_W-1:0]  ch;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] mask;
    logic              last;
  } entry_t;

  entry_t table_q [DEPTH];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    pass_q, pass_d;
  logic [CNT_W-1:0]    fail_q, fail_d;
  logic                pulse_q, pulse_d;
  logic                cpass_q, cpass_d;
  logic                ffv_q, ffv_d;
  logic [ADDR_W-1:0]   ffi_q, ffi_d;
  logic [DATA_W-1:0]   ffa_q, ffa_d;

  entry_t              cur_e;
  logic [ADDR_W-1:0]   idx_nxt;
  logic [DATA_W-1:0]   probe_sel;
  logic                ch_ok;
  logic                cmp_pass;
  logic                end_run;

  // Table is plain RAM: no reset, and frozen while a run is in flight.
  always_ff @(posedge CLK) begin
    if (cfg_we && state_q != S_WAIT && 32'(cfg_addr) < DEPTH) begin
      table_q[cfg_addr] <= '{cfg_delay, cfg_ch, cfg_value, cfg_mask, cfg_last};
    end
  end

  assign cur_e   = table_q[idx_q];
  assign idx_nxt = idx_q + ADDR_W'(1);
  assign end_run = cur_e.last || (32'(idx_q) == DEPTH - 1);

  // Out-of-range channels read as zero and always fail.
  always_comb begin
    probe_sel = '0;
    ch_ok     = 32'(cur_e.ch) < NUM_CH;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(cur_e.ch) == k) probe_sel = probe_data[k*DATA_W +: DATA_W];
    end
    cmp_pass = ch_ok && (((probe_sel ^ cur_e.value) & cur_e.mask) == '0);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    pulse_d = 1'b0;
    cpass_d = cpass_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    ffa_d   = ffa_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          idx_d   = '0;
          timer_d = table_q[0].delay;
          pass_d  = '0;
          fail_d  = '0;
          cpass_d = 1'b0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          ffa_d   = '0;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else begin
          pulse_d = 1'b1;
          cpass_d = cmp_pass;
          if (cmp_pass) begin
            if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
          end else begin
            if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = idx_q;
              ffa_d = probe_sel;
            end
          end
          // Next entry's delay loads on the compare edge so delay 0 runs back-to-back.
          if (end_run) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_nxt;
            timer_d = table_q[idx_nxt].delay;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      pulse_q <= 1'b0;
      cpass_q <= 1'b0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      ffa_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      pulse_q <= pulse_d;
      cpass_q <= cpass_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      ffa_q   <= ffa_d;
    end
  end

  assign busy              = (state_q == S_WAIT);
  assign done              = (state_q == S_DONE);
  assign pass_count        = pass_q;
  assign fail_count        = fail_q;
  assign cur_idx           = idx_q;
  assign check_pulse       = pulse_q;
  assign check_pass        = cpass_q;
  assign first_fail_valid  = ffv_q;
  assign first_fail_idx    = ffi_q;
  assign first_fail_actual = ffa_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Scoreboard bench: a table-walking reference model predicts every compare (edge, result)
// and the end-of-run counters; a monitor pops predictions whenever check_pulse is seen.
module tb_checkpoint_monitor;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 3;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;
  localparam int NOCUT  = 1 << 30;

  logic                     CLK = 1'b0;
  logic                     Reset = 1'b1;
  logic                     cfg_we = 1'b0;
  logic [ADDR_W-1:0]        cfg_addr = '0;
  logic [CNT_W-1:0]         cfg_delay = '0;
  logic [SEL_W-1:0]         cfg_ch = '0;
  logic [DATA_W-1:0]        cfg_value = '0;
  logic [DATA_W-1:0]        cfg_mask = '0;
  logic                     cfg_last = 1'b0;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic [NUM_CH*DATA_W-1:0] probe_data;
  logic                     busy, done, check_pulse, check_pass, first_fail_valid;
  logic [CNT_W-1:0]         pass_count, fail_count;
  logic [ADDR_W-1:0]        cur_idx, first_fail_idx;
  logic [DATA_W-1:0]        first_fail_actual;

  checkpoint_monitor #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DEPTH(DEPTH),
                       .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
    .cfg_ch(cfg_ch), .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_last(cfg_last),
    .start(start), .abort(abort), .probe_data(probe_data), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count), .cur_idx(cur_idx),
    .check_pulse(check_pulse), .check_pass(check_pass), .first_fail_valid(first_fail_valid),
    .first_fail_idx(first_fail_idx), .first_fail_actual(first_fail_actual));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [DATA_W-1:0] pr [NUM_CH];
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) probe_data[k*DATA_W +: DATA_W] = pr[k];
  end

  // Reference table and expected results.
  int                m_delay [DEPTH];
  int                m_ch    [DEPTH];
  logic [DATA_W-1:0] m_val   [DEPTH];
  logic [DATA_W-1:0] m_mask  [DEPTH];
  bit                m_last  [DEPTH];

  typedef struct { int edge_c; bit pass; } ev_t;
  ev_t exp_q [$];

  int                e_pass, e_fail, e_ffi, e_lasti;
  bit                e_ffv, e_done;
  logic [DATA_W-1:0] e_ffa;

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (check_pulse === 1'b1) begin
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_check: pulse at cycle %0d with nothing predicted", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.edge_c != cyc || e.pass != check_pass) begin
          fails++;
          $display("FAIL check_event: got cycle %0d pass %0b expected cycle %0d pass %0b",
                   cyc, check_pass, e.edge_c, e.pass);
        end
      end
    end
  end

  // Walk the table from a start edge; compares at or after 'cut' never happen.
  task automatic model_run(input int s, input int cut, output int last_edge);
    int t = s;
    e_pass = 0; e_fail = 0; e_ffv = 0; e_ffi = 0; e_ffa = '0; e_lasti = 0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [DATA_W-1:0] act;
      bit p;
      t += m_delay[i] + 1;
      act = (m_ch[i] < NUM_CH) ? pr[m_ch[i]] : '0;
      p = (m_ch[i] < NUM_CH) && ((act & m_mask[i]) == (m_val[i] & m_mask[i]));
      e_lasti = i;
      if (t < cut) begin
        exp_q.push_back('{t, p});
        if (p) e_pass++;
        else begin
          e_fail++;
          if (!e_ffv) begin e_ffv = 1; e_ffi = i; e_ffa = act; end
        end
      end
      if (m_last[i] || i == DEPTH - 1) break;
    end
    last_edge = t;
    e_done = (t < cut);
  endtask

  task automatic write_entry(input int a, input int d, input int ch, input logic [DATA_W-1:0] v,
                             input logic [DATA_W-1:0] m, input bit l, input bit upd);
    @(negedge CLK);
    cfg_addr = ADDR_W'(a); cfg_delay = CNT_W'(d); cfg_ch = SEL_W'(ch);
    cfg_value = v; cfg_mask = m; cfg_last = l; cfg_we = 1'b1;
    @(posedge CLK);
    #1 cfg_we = 1'b0;
    if (upd) begin
      m_delay[a] = d; m_ch[a] = ch; m_val[a] = v; m_mask[a] = m; m_last[a] = l;
    end
  endtask

  task automatic final_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 32'(e_done));
    chk({tag, "_pass_count"}, 32'(pass_count), e_pass);
    chk({tag, "_fail_count"}, 32'(fail_count), e_fail);
    chk({tag, "_ff_valid"}, 32'(first_fail_valid), 32'(e_ffv));
    if (e_ffv) begin
      chk({tag, "_ff_idx"}, 32'(first_fail_idx), e_ffi);
      chk({tag, "_ff_actual"}, 32'(first_fail_actual), 32'(e_ffa));
    end
    if (e_done) chk({tag, "_cur_idx"}, 32'(cur_idx), e_lasti);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // abort_after/reset_after: edges after the start edge (0 = none); sa drives start with abort.
  task automatic run(input string tag, input int abort_after, input bit wr_busy,
                     input int reset_after, input bit sa);
    int s, le, cut;
    @(negedge CLK);
    s = cyc + 1;
    cut = NOCUT;
    if (abort_after > 0) cut = s + abort_after;
    if (reset_after > 0) cut = s + reset_after;
    model_run(s, cut, le);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    if (wr_busy) begin
      repeat (2) @(negedge CLK);
      write_entry(1, 0, 0, 16'h0009, 16'hFFFF, 1'b1, 1'b0);
    end
    if (abort_after > 0) begin
      do @(negedge CLK); while (cyc < cut - 1);
      abort = 1'b1; start = sa;
      @(posedge CLK);
      #1 abort = 1'b0; start = 1'b0;
      @(posedge CLK);
      #1 final_checks(tag);
    end else if (reset_after > 0) begin
      do @(negedge CLK); while (cyc < cut - 1);
      @(posedge CLK);
      #1 Reset = 1'b1;
      #1;
      e_pass = 0; e_fail = 0; e_ffv = 0; e_done = 0;
      chk({tag, "_rst_pulse"}, 32'(check_pulse), 0);
      chk({tag, "_rst_idx"}, 32'(cur_idx), 0);
      chk({tag, "_rst_ffidx"}, 32'(first_fail_idx), 0);
      chk({tag, "_rst_ffact"}, 32'(first_fail_actual), 0);
      final_checks(tag);
      @(negedge CLK);
      Reset = 1'b0;
    end else begin
      do @(negedge CLK); while (done !== 1'b1 && cyc < le + 5);
      @(posedge CLK);
      #1 final_checks(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NUM_CH; k++) pr[k] = '0;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_pass", 32'(pass_count), 0);
    chk("reset_fail", 32'(fail_count), 0);
    chk("reset_idx", 32'(cur_idx), 0);
    chk("reset_pulse", 32'(check_pulse), 0);
    chk("reset_ffv", 32'(first_fail_valid), 0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    // Single entry, delay 3.
    pr[0] = 16'd4;
    write_entry(0, 3, 0, 16'd4, 16'hFFFF, 1'b1, 1'b1);
    run("single", 0, 0, 0, 0);

    // Back-to-back checks, one mismatch in the middle.
    pr[1] = 16'd2; pr[2] = 16'h1FFB; pr[3] = 16'd48;
    write_entry(0, 0, 1, 16'd2, 16'hFFFF, 1'b0, 1'b1);
    write_entry(1, 0, 2, 16'h1FFF, 16'hFFFF, 1'b0, 1'b1);
    write_entry(2, 0, 3, 16'd48, 16'hFFFF, 1'b1, 1'b1);
    run("b2b", 0, 0, 0, 0);

    // First failure is not overwritten by a later one.
    pr[0] = 16'h1111; pr[1] = 16'h2222; pr[2] = 16'h3333;
    write_entry(0, 1, 0, 16'h1112, 16'hFFFF, 1'b0, 1'b1);
    write_entry(1, 0, 1, 16'h2222, 16'hFFFF, 1'b0, 1'b1);
    write_entry(2, 2, 2, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    run("twofail", 0, 0, 0, 0);

    // Partial mask, zero mask, out-of-range channel.
    pr[0] = 16'hAB34; pr[3] = 16'h1234;
    write_entry(0, 0, 0, 16'h0034, 16'h00FF, 1'b0, 1'b1);
    write_entry(1, 1, 3, 16'hDEAD, 16'h0000, 1'b0, 1'b1);
    write_entry(2, 0, 5, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    run("mask_ch", 0, 0, 0, 0);

    // Run off the end of the table with no last flag.
    for (int i = 0; i < DEPTH; i++) write_entry(i, i % 2, i % 4, pr[i % 4], 16'hFFFF, 1'b0, 1'b1);
    run("tbl_end", 0, 0, 0, 0);

    // Reset mid-wait, then the untouched table reruns.
    pr[1] = 16'h0055; pr[2] = 16'h0066;
    write_entry(0, 6, 1, 16'h0055, 16'hFFFF, 1'b0, 1'b1);
    write_entry(1, 12, 2, 16'h0067, 16'hFFFF, 1'b1, 1'b1);
    run("midreset", 0, 0, 10, 0);
    run("after_rst", 0, 0, 0, 0);

    // Abort during a long delay with an ignored write; rerun; start+abort together.
    pr[0] = 16'd7;
    write_entry(0, 2, 0, 16'd7, 16'hFFFF, 1'b0, 1'b1);
    write_entry(1, 40, 0, 16'd7, 16'hFFFF, 1'b1, 1'b1);
    run("abort", 20, 1, 0, 0);
    run("post_abort", 0, 0, 0, 0);
    run("start_abort", 15, 0, 0, 1);

    // Randomized tables and probes, occasional aborts.
    for (int it = 0; it < 25; it++) begin
      int n, tot, ab;
      for (int k = 0; k < NUM_CH; k++) pr[k] = DATA_W'($urandom);
      n = $urandom_range(1, 6);
      tot = 0;
      for (int i = 0; i < n; i++) begin
        int d, ch;
        logic [DATA_W-1:0] v, m;
        d = $urandom_range(0, 4);
        ch = $urandom_range(0, 5);
        v = (ch < NUM_CH && $urandom_range(0, 1) == 1) ? pr[ch] : DATA_W'($urandom);
        if ($urandom_range(0, 3) == 0) v = v ^ DATA_W'(1 << $urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: m = 16'hFFFF;
          1: m = 16'h00FF;
          2: m = 16'h0000;
          default: m = DATA_W'($urandom);
        endcase
        tot += d + 1;
        write_entry(i, d, ch, v, m, i == n - 1, 1'b1);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot + 1) : 0;
      run("rand", ab, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
